// File: rtl/core_pkg.sv
// Shared core types for the uni_if bus arbiter: FSM states, grant ids and the CPU data-path width.
package core_pkg;

    // Mirrors CPU_WIDTH from the core configuration.
    localparam int CPU_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } arb_gnt_e;

endpackage

// File: rtl/uni_arb_pick.sv
// Combinational tie-break between the fetch and load/store requesters.
// UNI_ARB_RR_EN selects round-robin; otherwise the load/store port wins every tie.
module uni_arb_pick
    import core_pkg::*;
(
    input  logic     ifu_valid,
    input  logic     lsu_valid,
    input  arb_gnt_e last_gnt,
    output arb_gnt_e gnt,
    output logic     fire
);

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        fire = ifu_valid | lsu_valid;
        gnt  = GNT_IFU;
        if (ifu_valid && lsu_valid) begin
`ifdef UNI_ARB_RR_EN
            gnt = (last_gnt == GNT_IFU) ? GNT_LSU : GNT_IFU;
`else
            gnt = GNT_LSU;
`endif
        end else if (lsu_valid) begin
            gnt = GNT_LSU;
        end
    end

`ifndef UNI_ARB_RR_EN
    // Fixed priority never looks at the previous grant.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/uni_bus_arb.sv
// Merges the fetch and load/store uni_if masters onto one memory port, one transaction in flight.
// Tie-break policy lives in uni_arb_pick (UNI_ARB_RR_EN enables round-robin).
module uni_bus_arb
    import core_pkg::*;
#(
    parameter int ADDR_W = CPU_WIDTH,
    parameter int DATA_W = CPU_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ifu_req_valid,
    output logic                o_ifu_req_ready,
    input  logic [ADDR_W-1:0]   i_ifu_addr,
    output logic                o_ifu_rsp_valid,
    output logic [DATA_W-1:0]   o_ifu_rdata,
    input  logic                i_lsu_req_valid,
    output logic                o_lsu_req_ready,
    input  logic [ADDR_W-1:0]   i_lsu_addr,
    input  logic                i_lsu_wen,
    input  logic [DATA_W-1:0]   i_lsu_wdata,
    input  logic [DATA_W/8-1:0] i_lsu_wstrb,
    output logic                o_lsu_rsp_valid,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    input  logic                i_mem_rsp_valid,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    arb_gnt_e            gnt_q, pick_gnt;
    logic                pick_fire;
    logic                accept;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;

    uni_arb_pick u_pick (
        .ifu_valid (i_ifu_req_valid),
        .lsu_valid (i_lsu_req_valid),
        .last_gnt  (gnt_q),
        .gnt       (pick_gnt),
        .fire      (pick_fire)
    );

    assign accept = (state_q == IDLE) && pick_fire;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_fire)       state_d = REQ;
            REQ:     if (i_mem_req_ready) state_d = WAIT;
            WAIT:    if (i_mem_rsp_valid) state_d = RESP;
            RESP:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ifu_req_ready = 1'b0;
        o_lsu_req_ready = 1'b0;
        o_mem_req_valid = 1'b0;
        o_ifu_rsp_valid = 1'b0;
        o_lsu_rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_ifu_req_ready = pick_fire && (pick_gnt == GNT_IFU);
                o_lsu_req_ready = pick_fire && (pick_gnt == GNT_LSU);
            end
            REQ:  o_mem_req_valid = 1'b1;
            RESP: begin
                o_ifu_rsp_valid = (gnt_q == GNT_IFU);
                o_lsu_rsp_valid = (gnt_q == GNT_LSU);
            end
            default: ;
        endcase
    end

    // Fetches never write, so their write fields are forced to zero at capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gnt_q   <= GNT_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            gnt_q <= pick_gnt;
            if (pick_gnt == GNT_LSU) begin
                addr_q  <= i_lsu_addr;
                wen_q   <= i_lsu_wen;
                wdata_q <= i_lsu_wdata;
                wstrb_q <= i_lsu_wstrb;
            end else begin
                addr_q  <= i_ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
        end
    end

    // Per-port read data so each requester's rdata holds its own last value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else if ((state_q == WAIT) && i_mem_rsp_valid) begin
            if (gnt_q == GNT_LSU) lsu_rdata_q <= i_mem_rdata;
            else                  ifu_rdata_q <= i_mem_rdata;
        end
    end

    assign o_mem_addr  = addr_q;
    assign o_mem_wen   = wen_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wstrb = wstrb_q;
    assign o_ifu_rdata = ifu_rdata_q;
    assign o_lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_uni_bus_arb.sv
// Self-checking bench for uni_bus_arb: scoreboard of expected responses plus a small memory model.
// Honours UNI_ARB_RR_EN when predicting tie winners.
module tb_uni_bus_arb;
    import core_pkg::*;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [ADDR_W-1:0] ifu_addr;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_wen;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
    logic [STRB_W-1:0] lsu_wstrb;
    logic              mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [STRB_W-1:0] mem_wstrb;

    uni_bus_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_ifu_req_valid (ifu_req_valid),
        .o_ifu_req_ready (ifu_req_ready),
        .i_ifu_addr      (ifu_addr),
        .o_ifu_rsp_valid (ifu_rsp_valid),
        .o_ifu_rdata     (ifu_rdata),
        .i_lsu_req_valid (lsu_req_valid),
        .o_lsu_req_ready (lsu_req_ready),
        .i_lsu_addr      (lsu_addr),
        .i_lsu_wen       (lsu_wen),
        .i_lsu_wdata     (lsu_wdata),
        .i_lsu_wstrb     (lsu_wstrb),
        .o_lsu_rsp_valid (lsu_rsp_valid),
        .o_lsu_rdata     (lsu_rdata),
        .o_mem_req_valid (mem_req_valid),
        .i_mem_req_ready (mem_req_ready),
        .o_mem_addr      (mem_addr),
        .o_mem_wen       (mem_wen),
        .o_mem_wdata     (mem_wdata),
        .o_mem_wstrb     (mem_wstrb),
        .i_mem_rsp_valid (mem_rsp_valid),
        .i_mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_lsu;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   model_last_lsu = 1'b0;

    // Memory model knobs, written only by the main sequence.
    int   mem_ready_lat = 0;
    int   mem_rsp_lat   = 1;
    bit   mem_auto      = 1'b1;
    int   stray_req     = 0;
    int   stray_done    = 0;
    logic [ADDR_W-1:0] rsp_addr;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        if (a == 64'h8000_0000) return 64'h13;
        return {~a[31:0], a[31:0]};
    endfunction

    // Memory responder: ready after mem_ready_lat cycles, response mem_rsp_lat cycles after ready.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (stray_done != stray_req) begin
                stray_done++;
                mem_rsp_valid = 1'b1;
                mem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (mem_auto && mem_req_valid) begin
                rsp_addr = mem_addr;
                repeat (mem_ready_lat) begin @(posedge clk); #1; end
                mem_req_ready = 1'b1;
                @(posedge clk); #1;
                mem_req_ready = 1'b0;
                repeat (mem_rsp_lat - 1) begin @(posedge clk); #1; end
                mem_rsp_valid = 1'b1;
                mem_rdata     = mem_data(rsp_addr);
            end
        end
    end

    // Scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (ifu_rsp_valid || lsu_rsp_valid) begin
            if (ifu_rsp_valid && lsu_rsp_valid) begin
                check("rsp_both_ports", 1, 0);
            end else if (sb.size() == 0) begin
                check("rsp_unexpected", {ifu_rsp_valid, lsu_rsp_valid}, 0);
            end else begin
                e = sb.pop_front();
                check("rsp_port", lsu_rsp_valid, e.is_lsu);
                check("rsp_data", lsu_rsp_valid ? lsu_rdata : ifu_rdata, e.data);
            end
        end
    end

    task automatic push_exp(input bit is_lsu, input logic [DATA_W-1:0] d);
        exp_t e;
        e.is_lsu = is_lsu;
        e.data   = d;
        sb.push_back(e);
    endtask

    // Waits for the port's ready; 'now' demands acceptance in the current cycle.
    task automatic wait_accept(input bit is_lsu, input bit now);
        bit done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (is_lsu ? lsu_req_ready : ifu_req_ready) begin
                if (is_lsu) check("other_ready_ifu", ifu_req_ready, 0);
                else        check("other_ready_lsu", lsu_req_ready, 0);
                model_last_lsu = is_lsu;
                done = 1'b1;
                @(posedge clk); #1;
                if (is_lsu) lsu_req_valid = 1'b0;
                else        ifu_req_valid = 1'b0;
            end else if (now && c == 0) begin
                if (is_lsu) check("accept_now_lsu", 0, 1);
                else        check("accept_now_ifu", 0, 1);
            end
        end
        if (!done) check(is_lsu ? "accept_timeout_lsu" : "accept_timeout_ifu", 0, 1);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("drain_pending", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic tie(input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] la);
        bit lsu_wins;
`ifdef UNI_ARB_RR_EN
        lsu_wins = !model_last_lsu;
`else
        lsu_wins = 1'b1;
`endif
        ifu_addr  = ia;
        lsu_addr  = la;
        lsu_wen   = 1'b0;
        lsu_wdata = '0;
        lsu_wstrb = '1;
        if (lsu_wins) begin push_exp(1'b1, mem_data(la)); push_exp(1'b0, mem_data(ia)); end
        else          begin push_exp(1'b0, mem_data(ia)); push_exp(1'b1, mem_data(la)); end
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        wait_accept(lsu_wins, 1'b1);
        wait_accept(!lsu_wins, 1'b0);
        drain(40);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;

        // Reset state.
        #2;
        check("rst_ctrl", {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid, mem_req_valid, mem_wen}, 0);
        check("rst_data", {ifu_rdata, lsu_rdata, mem_addr, mem_wstrb}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: IFU fetch, minimum latency; garbage on LSU write fields must not leak.
        lsu_wen = 1'b1; lsu_wstrb = 8'hFF;
        ifu_addr = 64'h8000_0000;
        push_exp(1'b0, 64'h13);
        ifu_req_valid = 1'b1;
        wait_accept(1'b0, 1'b1);
        @(negedge clk);
        check("t1_mem_req_valid", mem_req_valid, 1);
        check("t1_mem_fields", {mem_addr, mem_wen, mem_wstrb}, {64'h8000_0000, 1'b0, 8'h00});
        @(negedge clk);
        check("t1_rsp_early", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        @(negedge clk);
        check("t1_rsp_t3", {ifu_rsp_valid, lsu_rsp_valid}, 2'b10);
        @(negedge clk);
        check("t1_rsp_pulse", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        check("t1_rdata_hold", ifu_rdata, 64'h13);
        drain(10);

        // 2: LSU store, memory stalls ready for 4 cycles.
        mem_ready_lat = 4;
        lsu_addr = 64'h8000_0100; lsu_wen = 1'b1; lsu_wdata = 64'hDEAD_BEEF; lsu_wstrb = 8'h0F;
        push_exp(1'b1, mem_data(64'h8000_0100));
        lsu_req_valid = 1'b1;
        wait_accept(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_req_hold", {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, lsu_req_ready},
                  {1'b1, 64'h8000_0100, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b0});
        end
        drain(20);
        mem_ready_lat = 0;

        // 4: stray memory responses in IDLE and REQ are ignored.
        mem_auto = 1'b0;
        stray_req++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_idle_quiet", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 0);
        end
        @(posedge clk); #1;
        ifu_addr = 64'h8000_0040;
        push_exp(1'b0, mem_data(64'h8000_0040));
        ifu_req_valid = 1'b1;
        wait_accept(1'b0, 1'b1);
        @(negedge clk);
        stray_req++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_req_stuck", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 3'b100);
        end
        mem_auto = 1'b1;
        drain(20);

        // 5: reset while waiting for the memory response.
        mem_rsp_lat = 6;
        lsu_addr = 64'h8000_0180; lsu_wen = 1'b0; lsu_wstrb = 8'hFF;
        lsu_req_valid = 1'b1;
        wait_accept(1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ctrl", {ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid, mem_req_valid, mem_wen}, 0);
        check("t5_rst_data", {ifu_rdata, lsu_rdata, mem_addr, mem_wstrb}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_after_rst", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 0);
        end
        mem_rsp_lat = 1;
        @(posedge clk); #1;
        ifu_addr = 64'h8000_0080;
        push_exp(1'b0, mem_data(64'h8000_0080));
        ifu_req_valid = 1'b1;
        wait_accept(1'b0, 1'b1);
        drain(20);

        // 3: simultaneous requests.
        tie(64'h8000_0004, 64'h8000_0200);
        tie(64'h8000_0008, 64'h8000_0300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
